cache_ctrl: RTL and testbench
=============================

CACHE_CTRL -- requirements
Module: cache_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 5, meaning word address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning data word width.
REQ-003 The block SHALL have parameter IDX_W, default 2, meaning index width (2**IDX_W lines); tag width = ADDR_W-IDX_W.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 req_valid  in  1  requester has a request.
REQ-007 req_ready  out  1  controller accepts request this cycle.
REQ-008 req_wr  in  1  1 = write, 0 = read.
REQ-009 req_addr  in  ADDR_W  word address.
REQ-010 req_wdata  in  DATA_W  write data.
REQ-011 resp_valid  out  1  one-cycle completion pulse.
REQ-012 resp_rdata  out  DATA_W  read data, valid with resp_valid.
REQ-013 resp_hit  out  1  read was a cache hit, valid with resp_valid.
REQ-014 flush  in  1  invalidate all lines.
REQ-015 mem_en, mem_wr  out  1 each  backing-RAM request / direction.
REQ-016 mem_addr  out  ADDR_W; mem_wdata  out  DATA_W; mem_rdata  in  DATA_W; mem_ack  in  1  RAM completion.
REQ-017 hit_cnt, miss_cnt  out  16 each  read hit / read miss counters.

Function
REQ-018 The block SHALL be a direct-mapped, write-through, no-write-allocate cache; index = addr[IDX_W-1:0], tag = addr[ADDR_W-1:IDX_W].
REQ-019 The FSM SHALL have states IDLE, LOOKUP, MEM_RD, MEM_WR, RESP; req_ready = 1 only in IDLE.
REQ-020 Accept = req_valid & req_ready; on accept, req_wr/addr/wdata SHALL be registered; read -> LOOKUP, write -> MEM_WR.
REQ-021 LOOKUP: valid[idx] & tag match -> RESP with stored data, resp_hit=1, hit_cnt+1; else -> MEM_RD, miss_cnt+1.
REQ-022 MEM_RD: mem_en=1, mem_wr=0, mem_addr=registered addr held until mem_ack; on mem_ack, line filled (data, tag, valid=1), resp_rdata=mem_rdata, resp_hit=0, -> RESP.
REQ-023 MEM_WR: mem_en=1, mem_wr=1, mem_addr/mem_wdata held until mem_ack; on mem_ack, if line valid with matching tag its data SHALL be updated, no allocation on miss, -> RESP.
REQ-024 RESP: resp_valid=1 exactly one cycle, then -> IDLE; write responses SHALL drive resp_rdata=0, resp_hit=0.
REQ-025 Latency: read hit resp_valid 2 cycles after accept edge; read miss / write 2 + (cycles until mem_ack) cycles.
REQ-026 mem_en SHALL be 0 in IDLE, LOOKUP, RESP; mem_ack outside MEM_RD/MEM_WR SHALL be ignored.
REQ-027 Counters SHALL saturate at 16'hFFFF, never wrap.
REQ-028 flush in IDLE SHALL clear all valid bits at that edge and suppress accept that cycle (req_ready=0 when flush=1).
REQ-029 flush while not IDLE SHALL be latched as pending and applied on the first IDLE cycle, after the in-flight fill/update.
REQ-030 Counters SHALL not be affected by flush.

Reset
REQ-031 On rst: state=IDLE, all valid bits=0, hit_cnt=miss_cnt=0, pending flush=0, resp_valid=0, resp_rdata=0, resp_hit=0, mem_en=0, mem_wr=0.
REQ-032 rst mid-transaction SHALL abandon it with no resp_valid; a late mem_ack after reset SHALL be ignored.
REQ-033 Data and tag arrays need not be reset.

Structure
REQ-034 State enum and default widths SHALL live in shared package cache_pkg.
REQ-035 The tag/valid/data storage SHALL be sub-module cache_lines (read index, write port, flush-all input); FSM and counters in cache_ctrl.

Verification
REQ-036 Read 0x05 cold, RAM returns 0xDEADBEEF after 3 cycles -> resp_hit=0, rdata 0xDEADBEEF, miss_cnt=1; re-read 0x05 -> hit, 2-cycle latency, hit_cnt=1, no mem_en.
REQ-037 Read 0x05 then read 0x09 (same index, tag differs) -> miss, refill; read 0x05 again -> miss, miss_cnt=3.
REQ-038 Read 0x02 (fill 0x11), write 0x02 = 0x22, read 0x02 -> hit, rdata 0x22; write 0x03 uncached then read 0x03 -> miss.
REQ-039 Assert flush during MEM_RD for 0x07 -> fill completes, resp_valid pulses, next read 0x07 misses.
REQ-040 Assert rst while in MEM_WR with mem_ack withheld -> no resp_valid, outputs at reset values, counters 0, next request accepted normally.
REQ-041 Force 65536 hits -> hit_cnt stays 16'hFFFF.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared state encoding and default sizes for the direct-mapped cache controller.
package cache_pkg;

   localparam int ADDR_W_DEF = 5;
   localparam int DATA_W_DEF = 32;
   localparam int IDX_W_DEF  = 2;
   localparam int CNT_W_DEF  = 16;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOOKUP = 3'd1,
      MEM_RD = 3'd2,
      MEM_WR = 3'd3,
      RESP   = 3'd4
   } state_t;

endpackage

// File: rtl/cache_ctrl_if.sv
// Request/response, backing-RAM and counter signals of the cache controller.
// A request transfers on a rising edge with req_valid & req_ready; resp_valid is a
// one-cycle pulse without back-pressure; mem_* requests stay stable until mem_ack.
interface cache_ctrl_if import cache_pkg::*; #(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) ();

   logic              req_valid;
   logic              req_ready;
   logic              req_wr;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              resp_valid;
   logic [DATA_W-1:0] resp_rdata;
   logic              resp_hit;
   logic              flush;
   logic              mem_en;
   logic              mem_wr;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;
   logic [CNT_W-1:0]  hit_cnt;
   logic [CNT_W-1:0]  miss_cnt;

   modport slave (
      input  req_valid, req_wr, req_addr, req_wdata, flush, mem_rdata, mem_ack,
      output req_ready, resp_valid, resp_rdata, resp_hit,
             mem_en, mem_wr, mem_addr, mem_wdata, hit_cnt, miss_cnt
   );

   modport master (
      output req_valid, req_wr, req_addr, req_wdata, flush, mem_rdata, mem_ack,
      input  req_ready, resp_valid, resp_rdata, resp_hit,
             mem_en, mem_wr, mem_addr, mem_wdata, hit_cnt, miss_cnt
   );

endinterface

// File: rtl/cache_lines.sv
// Tag/valid/data storage for a direct-mapped cache: asynchronous read by index,
// one write port that fills a whole line, and a flush that clears every valid bit.
module cache_lines import cache_pkg::*; #(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int IDX_W  = IDX_W_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [IDX_W-1:0]        rd_idx,
   output logic                    rd_valid,
   output logic [ADDR_W-IDX_W-1:0] rd_tag,
   output logic [DATA_W-1:0]       rd_data,
   input  logic                    wr_en,
   input  logic [IDX_W-1:0]        wr_idx,
   input  logic [ADDR_W-IDX_W-1:0] wr_tag,
   input  logic [DATA_W-1:0]       wr_data,
   input  logic                    flush_all
);

   localparam int LINES = 1 << IDX_W;
   localparam int TAG_W = ADDR_W - IDX_W;

   logic [LINES-1:0]  valid;
   logic [TAG_W-1:0]  tags  [LINES];
   logic [DATA_W-1:0] lines [LINES];

   // Flush never coincides with a fill; giving it priority keeps the clear absolute.
   always_ff @(posedge clk) begin
      if (rst || flush_all) begin
         valid <= '0;
      end else if (wr_en) begin
         valid[wr_idx] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         tags[wr_idx]  <= wr_tag;
         lines[wr_idx] <= wr_data;
      end
   end

   assign rd_valid = valid[rd_idx];
   assign rd_tag   = tags[rd_idx];
   assign rd_data  = lines[rd_idx];

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller with
// saturating read hit/miss counters and deferred flush.
module cache_ctrl import cache_pkg::*; #(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int IDX_W  = IDX_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic        clk,
   input  logic        rst,
   cache_ctrl_if.slave bus,
   output state_t      fsm_state
);

   localparam int TAG_W = ADDR_W - IDX_W;

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              flush_pend;
   logic [CNT_W-1:0]  hit_cnt_q;
   logic [CNT_W-1:0]  miss_cnt_q;
   logic [DATA_W-1:0] rdata_q;
   logic              hit_q;

   logic              accept;
   logic              flush_now;
   logic              line_hit;
   logic [IDX_W-1:0]  idx_q;
   logic [TAG_W-1:0]  tag_q;
   logic              rd_valid;
   logic [TAG_W-1:0]  rd_tag;
   logic [DATA_W-1:0] rd_data;

   logic              line_we;
   logic [DATA_W-1:0] line_wdata;
   logic              resp_ld;
   logic [DATA_W-1:0] resp_rdata_d;
   logic              resp_hit_d;
   logic              hit_inc;
   logic              miss_inc;

   assign idx_q     = addr_q[IDX_W-1:0];
   assign tag_q     = addr_q[ADDR_W-1:IDX_W];
   assign accept    = bus.req_valid && bus.req_ready;
   // A flush seen outside IDLE waits so the in-flight fill/update lands first.
   assign flush_now = (state == IDLE) && (bus.flush || flush_pend);
   assign line_hit  = rd_valid && (rd_tag == tag_q);

   cache_lines #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .IDX_W  (IDX_W)
   ) u_lines (
      .clk       (clk),
      .rst       (rst),
      .rd_idx    (idx_q),
      .rd_valid  (rd_valid),
      .rd_tag    (rd_tag),
      .rd_data   (rd_data),
      .wr_en     (line_we),
      .wr_idx    (idx_q),
      .wr_tag    (tag_q),
      .wr_data   (line_wdata),
      .flush_all (flush_now)
   );

   always_comb begin
      state_nxt    = state;
      line_we      = 1'b0;
      line_wdata   = wdata_q;
      resp_ld      = 1'b0;
      resp_rdata_d = '0;
      resp_hit_d   = 1'b0;
      hit_inc      = 1'b0;
      miss_inc     = 1'b0;
      case (state)
         IDLE: begin
            if (accept) state_nxt = bus.req_wr ? MEM_WR : LOOKUP;
         end
         LOOKUP: begin
            if (line_hit) begin
               state_nxt    = RESP;
               resp_ld      = 1'b1;
               resp_rdata_d = rd_data;
               resp_hit_d   = 1'b1;
               hit_inc      = 1'b1;
            end else begin
               state_nxt = MEM_RD;
               miss_inc  = 1'b1;
            end
         end
         MEM_RD: begin
            if (bus.mem_ack) begin
               state_nxt    = RESP;
               line_we      = 1'b1;
               line_wdata   = bus.mem_rdata;
               resp_ld      = 1'b1;
               resp_rdata_d = bus.mem_rdata;
            end
         end
         MEM_WR: begin
            // Write-through: refresh the line only when it already holds this address.
            if (bus.mem_ack) begin
               state_nxt = RESP;
               line_we   = line_hit;
               resp_ld   = 1'b1;
            end
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         flush_pend <= 1'b0;
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
         rdata_q    <= '0;
         hit_q      <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == IDLE) begin
            flush_pend <= 1'b0;
         end else if (bus.flush) begin
            flush_pend <= 1'b1;
         end
         if (resp_ld) begin
            rdata_q <= resp_rdata_d;
            hit_q   <= resp_hit_d;
         end
         if (hit_inc && (hit_cnt_q != '1)) hit_cnt_q <= hit_cnt_q + CNT_W'(1);
         if (miss_inc && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         addr_q  <= bus.req_addr;
         wdata_q <= bus.req_wdata;
      end
   end

   assign bus.req_ready  = (state == IDLE) && !bus.flush;
   assign bus.resp_valid = (state == RESP);
   assign bus.resp_rdata = rdata_q;
   assign bus.resp_hit   = hit_q;
   assign bus.mem_en     = (state == MEM_RD) || (state == MEM_WR);
   assign bus.mem_wr     = (state == MEM_WR);
   assign bus.mem_addr   = addr_q;
   assign bus.mem_wdata  = wdata_q;
   assign bus.hit_cnt    = hit_cnt_q;
   assign bus.miss_cnt   = miss_cnt_q;
   assign fsm_state      = state;

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl: a RAM model answers mem requests, expected
// responses are queued at accept and checked by an independent response monitor.
module tb_cache_ctrl;
   import cache_pkg::*;

   localparam int ADDR_W   = 5;
   localparam int DATA_W   = 32;
   localparam int IDX_W    = 2;
   // Narrow counters make saturation reachable within a short run.
   localparam int CNT_W    = 10;
   localparam int CNT_MAX  = (1 << CNT_W) - 1;
   localparam int SB_W     = DATA_W + 1;

   logic   clk = 1'b0;
   logic   rst = 1'b1;
   state_t fsm_state;

   cache_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

   cache_ctrl #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .IDX_W  (IDX_W),
      .CNT_W  (CNT_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus.slave),
      .fsm_state (fsm_state)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   logic [SB_W-1:0]   exp_q[$];
   logic [SB_W-1:0]   exp_v;
   int                n_tests = 0;
   int                n_fail = 0;
   int                resp_seen = 0;
   int                resp_cyc = 0;
   int                acc_cyc = 0;
   int                mem_en_cycles = 0;

   logic [DATA_W-1:0] ram [32];
   int                mem_delay = 3;
   bit                mem_hold = 1'b0;
   bit                inject_ack = 1'b0;
   int                mem_wait = 0;

   // RAM model: acknowledges after mem_delay cycles of mem_en unless held.
   always @(negedge clk) begin
      bus.mem_ack   = inject_ack;
      bus.mem_rdata = inject_ack ? 32'hBAD0_0BAD : '0;
      if (bus.mem_en && !mem_hold) begin
         mem_wait++;
         if (mem_wait >= mem_delay) begin
            bus.mem_ack = 1'b1;
            if (bus.mem_wr) ram[bus.mem_addr] = bus.mem_wdata;
            else bus.mem_rdata = ram[bus.mem_addr];
            mem_wait = 0;
         end
      end else begin
         mem_wait = 0;
      end
      if (bus.mem_en) mem_en_cycles++;
   end

   always @(negedge clk) begin
      if (!rst && bus.resp_valid) begin
         resp_seen++;
         resp_cyc = cyc;
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_resp: got hit=%0b rdata=%h, no response expected",
                     bus.resp_hit, bus.resp_rdata);
         end else begin
            exp_v = exp_q.pop_front();
            if ({bus.resp_hit, bus.resp_rdata} !== exp_v) begin
               n_fail++;
               $display("FAIL resp: got hit=%0b rdata=%h, expected hit=%0b rdata=%h",
                        bus.resp_hit, bus.resp_rdata, exp_v[SB_W-1], exp_v[DATA_W-1:0]);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic issue(input bit wr, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                        input bit push, input bit exp_hit, input logic [DATA_W-1:0] exp_rdata);
      int guard;
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_wr    = wr;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      guard = 0;
      while (!bus.req_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (!bus.req_ready) begin
         n_tests++;
         n_fail++;
         $display("FAIL accept_timeout: req_ready=0 after %0d cycles, required 1", guard);
      end else begin
         @(posedge clk);
         #1;
         acc_cyc = cyc;
         if (push) exp_q.push_back({exp_hit, exp_rdata});
      end
      @(negedge clk);
      bus.req_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      int guard;
      guard = 0;
      while ((exp_q.size() != 0 || fsm_state != IDLE) && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      n_tests++;
      if (guard >= 100) begin
         n_fail++;
         $display("FAIL %s_timeout: %0d responses outstanding, required 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic txn(input string name, input bit wr, input logic [ADDR_W-1:0] addr,
                      input logic [DATA_W-1:0] wdata, input bit exp_hit, input logic [DATA_W-1:0] exp_rdata);
      issue(wr, addr, wdata, 1'b1, exp_hit, exp_rdata);
      drain(name);
   endtask

   initial begin
      #500_000;
      $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "global timeout");
   end

   initial begin
      int mem_before;
      int seen_before;
      int g;
      bus.req_valid = 1'b0;
      bus.req_wr    = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      bus.flush     = 1'b0;
      for (int i = 0; i < 32; i++) ram[i] = 32'h1000_0000 + i;
      ram[5'h05] = 32'hDEAD_BEEF;
      ram[5'h09] = 32'h0909_0909;
      ram[5'h02] = 32'h0000_0011;
      ram[5'h03] = 32'h0000_0033;
      ram[5'h07] = 32'h0000_0077;
      ram[5'h0A] = 32'h0000_AAAA;

      repeat (3) @(negedge clk);
      check("rst_state", 32'(fsm_state), 32'(IDLE));
      check("rst_resp_valid", 32'(bus.resp_valid), 0);
      check("rst_resp_rdata", bus.resp_rdata, 0);
      check("rst_mem_en", 32'(bus.mem_en), 0);
      check("rst_hit_cnt", 32'(bus.hit_cnt), 0);
      check("rst_miss_cnt", 32'(bus.miss_cnt), 0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_req_ready", 32'(bus.req_ready), 1);

      txn("cold_read_05", 1'b0, 5'h05, '0, 1'b0, 32'hDEAD_BEEF);
      check("miss_latency", 32'(resp_cyc + 1 - acc_cyc), 2 + 3);
      check("miss_cnt_1", 32'(bus.miss_cnt), 1);
      mem_before = mem_en_cycles;
      txn("hit_read_05", 1'b0, 5'h05, '0, 1'b1, 32'hDEAD_BEEF);
      check("hit_latency", 32'(resp_cyc + 1 - acc_cyc), 2);
      check("hit_no_mem_en", 32'(mem_en_cycles - mem_before), 0);
      check("hit_cnt_1", 32'(bus.hit_cnt), 1);

      txn("conflict_read_09", 1'b0, 5'h09, '0, 1'b0, 32'h0909_0909);
      txn("evicted_read_05", 1'b0, 5'h05, '0, 1'b0, 32'hDEAD_BEEF);
      check("miss_cnt_3", 32'(bus.miss_cnt), 3);

      txn("fill_read_02", 1'b0, 5'h02, '0, 1'b0, 32'h0000_0011);
      txn("write_hit_02", 1'b1, 5'h02, 32'h0000_0022, 1'b0, 32'h0);
      check("ram_written_02", ram[5'h02], 32'h0000_0022);
      txn("reread_02", 1'b0, 5'h02, '0, 1'b1, 32'h0000_0022);
      txn("write_miss_03", 1'b1, 5'h03, 32'h0000_003C, 1'b0, 32'h0);
      txn("read_03_no_alloc", 1'b0, 5'h03, '0, 1'b0, 32'h0000_003C);
      check("hit_cnt_2", 32'(bus.hit_cnt), 2);
      check("miss_cnt_5", 32'(bus.miss_cnt), 5);

      mem_delay = 4;
      fork
         txn("flush_during_fill_07", 1'b0, 5'h07, '0, 1'b0, 32'h0000_0077);
         begin : flusher
            g = 0;
            while (fsm_state != MEM_RD && g < 50) begin
               @(negedge clk);
               g++;
            end
            bus.flush = 1'b1;
            @(negedge clk);
            bus.flush = 1'b0;
         end
      join
      mem_delay = 3;
      txn("read_07_after_flush", 1'b0, 5'h07, '0, 1'b0, 32'h0000_0077);
      txn("refill_05", 1'b0, 5'h05, '0, 1'b0, 32'hDEAD_BEEF);

      @(negedge clk);
      bus.flush     = 1'b1;
      bus.req_valid = 1'b1;
      bus.req_wr    = 1'b0;
      bus.req_addr  = 5'h05;
      #1;
      check("flush_blocks_ready", 32'(bus.req_ready), 0);
      @(negedge clk);
      bus.flush     = 1'b0;
      bus.req_valid = 1'b0;
      check("flush_no_accept", 32'(fsm_state), 32'(IDLE));
      txn("read_05_after_idle_flush", 1'b0, 5'h05, '0, 1'b0, 32'hDEAD_BEEF);
      check("miss_cnt_9", 32'(bus.miss_cnt), 9);
      check("flush_keeps_hit_cnt", 32'(bus.hit_cnt), 2);

      mem_hold = 1'b1;
      seen_before = resp_seen;
      issue(1'b1, 5'h0A, 32'h1234_5678, 1'b0, 1'b0, 32'h0);
      g = 0;
      while (fsm_state != MEM_WR && g < 50) begin
         @(negedge clk);
         g++;
      end
      repeat (2) @(negedge clk);
      check("memwr_hold_en", 32'({bus.mem_en, bus.mem_wr}), 32'h3);
      check("memwr_hold_addr", 32'(bus.mem_addr), 32'h0A);
      check("memwr_hold_wdata", bus.mem_wdata, 32'h1234_5678);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      mem_hold = 1'b0;
      check("midrst_state", 32'(fsm_state), 32'(IDLE));
      check("midrst_mem_en", 32'({bus.mem_en, bus.mem_wr}), 0);
      check("midrst_resp", 32'({bus.resp_valid, bus.resp_hit}), 0);
      check("midrst_resp_rdata", bus.resp_rdata, 0);
      check("midrst_counters", 32'({bus.hit_cnt, bus.miss_cnt}), 0);
      inject_ack = 1'b1;
      repeat (2) @(negedge clk);
      inject_ack = 1'b0;
      repeat (2) @(negedge clk);
      check("late_ack_ignored", 32'(fsm_state), 32'(IDLE));
      check("abandoned_no_resp", 32'(resp_seen - seen_before), 0);
      txn("read_after_rst_05", 1'b0, 5'h05, '0, 1'b0, 32'hDEAD_BEEF);
      check("miss_cnt_after_rst", 32'(bus.miss_cnt), 1);

      for (int i = 0; i < CNT_MAX + 6; i++) begin
         txn("sat_hit_05", 1'b0, 5'h05, '0, 1'b1, 32'hDEAD_BEEF);
         if (i == CNT_MAX - 1) check("hit_cnt_at_max", 32'(bus.hit_cnt), CNT_MAX);
      end
      check("hit_cnt_saturated", 32'(bus.hit_cnt), CNT_MAX);
      check("miss_cnt_unchanged", 32'(bus.miss_cnt), 1);

      repeat (3) @(negedge clk);
      check("no_leftover_exp", 32'(exp_q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
